pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Hazard/stall controller for the 5-stage pipeline. It drives the write-enables and
//   flush/bubble controls of the PC, IF/ID, ID/EXE and EXE/MEM registers.
//   Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
//   Multi-cycle waits have a timeout that halts the pipe. Also keeps saturating stall/flush counters.
// PARAMETERS
//   TIMEOUT  16  consecutive MEM_Busy cycles before HALT (>=2)
//   CNT_W    16  width of performance counters
// PORTS
//   CLK            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-low
//   ID_Rs          in   5      source reg A of instr in ID
//   ID_Rt          in   5      source reg B of instr in ID
//   ID_UsesRt      in   1      instr in ID reads Rt
//   EXE_MemtoReg   in   1      instr in EXE is a load
//   EXE_RegWr      in   1      instr in EXE writes a register
//   EXE_Rw         in   5      dest reg of instr in EXE
//   EXE_BrTaken    in   1      branch resolved taken in EXE
//   MEM_Busy       in   1      data memory not ready this cycle
//   Cnt_Clr        in   1      synchronous clear of counters
//   PC_Wr          out  1      PC load enable
//   IF_ID_Wr       out  1      IF/ID load enable
//   IF_ID_Flush    out  1      IF/ID loads zero (NOP)
//   ID_EXE_Wr      out  1      ID/EXE load enable
//   ID_EXE_Bubble  out  1      ID/EXE loads zero controls (bubble)
//   EXE_MEM_Wr     out  1      EXE/MEM load enable
//   MEM_WB_Bubble  out  1      MEM/WB loads zero controls
//   Mem_Err        out  1      sticky: timeout occurred
//   Stall_Cnt      out  CNT_W  stall cycles (load-use + freeze)
//   Flush_Cnt      out  CNT_W  branch flush events
// BEHAVIOUR
//   States: RUN, WAIT, HALT. Reset -> RUN, busy_cyc=0, Mem_Err=0, counters=0.
//   While reset low: all *_Wr=0, all flush/bubble=0.
//   Controls are combinational from state + inputs; they take effect in the same cycle.
//   loaduse = EXE_MemtoReg & EXE_RegWr & (EXE_Rw!=0) &
//             (EXE_Rw==ID_Rs | (ID_UsesRt & EXE_Rw==ID_Rt))
//   freeze  = MEM_Busy | (state==HALT)
//   Priority per cycle: freeze > EXE_BrTaken > loaduse > normal.
//   - normal:  all *_Wr=1, all flush/bubble=0.
//   - freeze:  PC_Wr=IF_ID_Wr=ID_EXE_Wr=EXE_MEM_Wr=0, MEM_WB_Bubble=1, others 0.
//              A branch or load-use present during freeze is acted on once freeze ends.
//   - branch:  all *_Wr=1, IF_ID_Flush=1, ID_EXE_Bubble=1 (squash 2 wrong-path instrs).
//              A simultaneous loaduse is ignored.
//   - loaduse: PC_Wr=IF_ID_Wr=0, ID_EXE_Bubble=1, ID_EXE_Wr=EXE_MEM_Wr=1.
//              Exactly 1 cycle, because the load has moved to MEM on the next cycle.
//   FSM:
//     RUN -> WAIT when MEM_Busy=1.
//     WAIT -> RUN when MEM_Busy=0.
//     WAIT -> HALT at the edge ending the TIMEOUT-th consecutive busy cycle; Mem_Err<=1.
//     HALT: absorbing until reset; MEM_Busy ignored.
//   busy_cyc: +1 per MEM_Busy=1 cycle outside HALT, cleared when MEM_Busy=0.
//     Width is clog2(TIMEOUT+1).
//   Stall_Cnt: +1 per cycle of loaduse stall or freeze, excluding HALT.
//   Flush_Cnt: +1 per branch-flush cycle.
//   Both counters saturate at all-ones. Cnt_Clr has priority over increment (result 0).
//   Reset mid-stall/mid-wait: immediate return to RUN with the reset values above.
// TESTING
//   1 lw r2 in EXE (EXE_Rw=2), ID_Rs=2 -> one cycle PC_Wr=0, IF_ID_Wr=0, ID_EXE_Bubble=1;
//     Stall_Cnt=1.
//   2 Same as 1 but EXE_Rw=0, or ID_UsesRt=0 with ID_Rt=2 and ID_Rs!=2 -> no stall.
//   3 EXE_BrTaken=1 plus loaduse same cycle -> IF_ID_Flush=1, ID_EXE_Bubble=1, PC_Wr=1;
//     Flush_Cnt=1, Stall_Cnt unchanged.
//   4 MEM_Busy high 3 cycles with EXE_BrTaken=1 -> 3 freeze cycles with MEM_WB_Bubble=1,
//     then flush on cycle 4; Stall_Cnt=3.
//   5 MEM_Busy held 16 cycles (TIMEOUT=16) -> HALT, Mem_Err=1, freeze persists after
//     MEM_Busy drops; reset low -> RUN, Mem_Err=0.
//   6 CNT_W=4: 20 load-use stalls -> Stall_Cnt=15 (saturated); Cnt_Clr with a stall
//     in the same cycle -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory waits with a timeout halt, and saturating stall/flush counters.
//
// state | meaning
// RUN   | normal issue; stall/flush decided per cycle from inputs
// WAIT  | data memory busy; counting consecutive busy cycles toward the timeout
// HALT  | memory timed out; pipe frozen until reset
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EXE_MemtoReg,
  input  logic             EXE_RegWr,
  input  logic [4:0]       EXE_Rw,
  input  logic             EXE_BrTaken,
  input  logic             MEM_Busy,
  input  logic             Cnt_Clr,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EXE_Wr,
  output logic             ID_EXE_Bubble,
  output logic             EXE_MEM_Wr,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam int BW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    busy_cyc_q, busy_cyc_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic loaduse, freeze, do_branch, do_loaduse;

  assign loaduse = EXE_MemtoReg & EXE_RegWr & (EXE_Rw != 5'd0) &
                   ((EXE_Rw == ID_Rs) | (ID_UsesRt & (EXE_Rw == ID_Rt)));
  assign freeze     = MEM_Busy | (state_q == HALT);
  assign do_branch  = ~freeze & EXE_BrTaken;
  assign do_loaduse = ~freeze & ~EXE_BrTaken & loaduse;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      busy_cyc_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cyc_q  <= busy_cyc_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_cyc_d  = busy_cyc_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    PC_Wr         = 1'b1;
    IF_ID_Wr      = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EXE_Wr     = 1'b1;
    ID_EXE_Bubble = 1'b0;
    EXE_MEM_Wr    = 1'b1;
    MEM_WB_Bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (MEM_Busy) begin
          state_d    = WAIT;
          busy_cyc_d = busy_cyc_q + BW'(1);
        end else begin
          busy_cyc_d = '0;
        end
      end
      WAIT: begin
        if (!MEM_Busy) begin
          state_d    = RUN;
          busy_cyc_d = '0;
        end else begin
          busy_cyc_d = busy_cyc_q + BW'(1);
          // this busy cycle is the TIMEOUT-th in a row
          if (busy_cyc_q == BW'(TIMEOUT - 1)) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end
        end
      end
      HALT: state_d = HALT;
      default: begin
        state_d    = RUN;
        busy_cyc_d = '0;
      end
    endcase

    if (freeze) begin
      PC_Wr         = 1'b0;
      IF_ID_Wr      = 1'b0;
      ID_EXE_Wr     = 1'b0;
      EXE_MEM_Wr    = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (do_branch) begin
      IF_ID_Flush   = 1'b1;
      ID_EXE_Bubble = 1'b1;
    end else if (do_loaduse) begin
      PC_Wr         = 1'b0;
      IF_ID_Wr      = 1'b0;
      ID_EXE_Bubble = 1'b1;
    end

    if (Cnt_Clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (((freeze && state_q != HALT) || do_loaduse) && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (do_branch && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // controls are forced inactive for as long as reset is held
    if (!reset) begin
      PC_Wr         = 1'b0;
      IF_ID_Wr      = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EXE_Wr     = 1'b0;
      ID_EXE_Bubble = 1'b0;
      EXE_MEM_Wr    = 1'b0;
      MEM_WB_Bubble = 1'b0;
    end
  end

  assign Mem_Err   = mem_err_q;
  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for per-cycle controls plus
// sequences for counters, memory waits, timeout halt, reset and saturation.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EXE_Rw;
  logic        ID_UsesRt, EXE_MemtoReg, EXE_RegWr, EXE_BrTaken, MEM_Busy, Cnt_Clr;

  logic        pc_wr_a, ifid_wr_a, ifid_fl_a, idex_wr_a, idex_bb_a, exmem_wr_a, memwb_bb_a, err_a;
  logic [15:0] stall_a, flush_a;
  logic        pc_wr_b, ifid_wr_b, ifid_fl_b, idex_wr_b, idex_bb_b, exmem_wr_b, memwb_bb_b, err_b;
  logic [3:0]  stall_b, flush_b;

  logic [6:0]  ctrl_a, ctrl_b;
  assign ctrl_a = {pc_wr_a, ifid_wr_a, ifid_fl_a, idex_wr_a, idex_bb_a, exmem_wr_a, memwb_bb_a};
  assign ctrl_b = {pc_wr_b, ifid_wr_b, ifid_fl_b, idex_wr_b, idex_bb_b, exmem_wr_b, memwb_bb_b};

  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut_a (
    .CLK(CLK), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWr(EXE_RegWr), .EXE_Rw(EXE_Rw),
    .EXE_BrTaken(EXE_BrTaken), .MEM_Busy(MEM_Busy), .Cnt_Clr(Cnt_Clr),
    .PC_Wr(pc_wr_a), .IF_ID_Wr(ifid_wr_a), .IF_ID_Flush(ifid_fl_a), .ID_EXE_Wr(idex_wr_a),
    .ID_EXE_Bubble(idex_bb_a), .EXE_MEM_Wr(exmem_wr_a), .MEM_WB_Bubble(memwb_bb_a),
    .Mem_Err(err_a), .Stall_Cnt(stall_a), .Flush_Cnt(flush_a));

  pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut_b (
    .CLK(CLK), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWr(EXE_RegWr), .EXE_Rw(EXE_Rw),
    .EXE_BrTaken(EXE_BrTaken), .MEM_Busy(MEM_Busy), .Cnt_Clr(Cnt_Clr),
    .PC_Wr(pc_wr_b), .IF_ID_Wr(ifid_wr_b), .IF_ID_Flush(ifid_fl_b), .ID_EXE_Wr(idex_wr_b),
    .ID_EXE_Bubble(idex_bb_b), .EXE_MEM_Wr(exmem_wr_b), .MEM_WB_Bubble(memwb_bb_b),
    .Mem_Err(err_b), .Stall_Cnt(stall_b), .Flush_Cnt(flush_b));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       m2r;
    logic       rwr;
    logic [4:0] rw;
    logic       br;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic m2r, input logic rwr, input logic [4:0] rw,
                       input logic br, input logic busy);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = urt; EXE_MemtoReg = m2r;
    EXE_RegWr = rwr; EXE_Rw = rw; EXE_BrTaken = br; MEM_Busy = busy;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_cnt();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    Cnt_Clr = 1'b1;
    step();
    Cnt_Clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rs     rt     urt   m2r   rwr   rw     br    busy  expected
    vecs[0] = '{5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 5'd2,  1'b0, 1'b0, C_LDUSE};
    vecs[1] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, C_NORM};
    vecs[2] = '{5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 5'd2,  1'b0, 1'b0, C_NORM};
    vecs[3] = '{5'd3,  5'd2,  1'b1, 1'b1, 1'b1, 5'd2,  1'b0, 1'b0, C_LDUSE};
    vecs[4] = '{5'd2,  5'd2,  1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, C_NORM};
    vecs[5] = '{5'd2,  5'd2,  1'b1, 1'b1, 1'b0, 5'd2,  1'b0, 1'b0, C_NORM};
    vecs[6] = '{5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 5'd2,  1'b1, 1'b0, C_BRANCH};
    vecs[7] = '{5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 5'd2,  1'b1, 1'b1, C_FREEZE};
    vecs[8] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, C_NORM};
    vecs[9] = '{5'd31, 5'd1,  1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, C_LDUSE};

    reset = 1'b0;
    Cnt_Clr = 1'b0;
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    #2;
    chk("reset_ctrl", 32'(ctrl_a), 32'(7'b0));
    chk("reset_err", 32'(err_a), 32'd0);
    chk("reset_stall", 32'(stall_a), 32'd0);
    chk("reset_flush", 32'(flush_a), 32'd0);
    step();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].m2r, vecs[i].rwr,
            vecs[i].rw, vecs[i].br, vecs[i].busy);
      #1;
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_a), 32'(vecs[i].exp));
      step();
    end

    // single load-use stall
    clear_cnt();
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("lu_after_ctrl", 32'(ctrl_a), 32'(C_NORM));
    chk("lu_stall_cnt", 32'(stall_a), 32'd1);
    chk("lu_flush_cnt", 32'(flush_a), 32'd0);

    // branch beats load-use
    clear_cnt();
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    chk("br_flush_cnt", 32'(flush_a), 32'd1);
    chk("br_stall_cnt", 32'(stall_a), 32'd0);

    // branch held during a 3-cycle memory wait, acted on afterwards
    clear_cnt();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      #1;
      chk($sformatf("wait3_c%0d_ctrl", i), 32'(ctrl_a), 32'(C_FREEZE));
      step();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    chk("wait3_c3_ctrl", 32'(ctrl_a), 32'(C_BRANCH));
    step();
    chk("wait3_stall_cnt", 32'(stall_a), 32'd3);
    chk("wait3_flush_cnt", 32'(flush_a), 32'd1);

    // 15 busy cycles: one short of the timeout
    clear_cnt();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("busy15_ctrl", 32'(ctrl_a), 32'(C_NORM));
    step();
    chk("busy15_err", 32'(err_a), 32'd0);
    chk("busy15_stall_cnt", 32'(stall_a), 32'd15);

    // 16 busy cycles: timeout into HALT
    clear_cnt();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step();
    chk("busy16_err_before", 32'(err_a), 32'd0);
    step();
    chk("busy16_err", 32'(err_a), 32'd1);
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    #1;
    chk("halt_ctrl", 32'(ctrl_a), 32'(C_FREEZE));
    step();
    step();
    chk("halt_ctrl_later", 32'(ctrl_a), 32'(C_FREEZE));
    chk("halt_stall_cnt", 32'(stall_a), 32'd16);
    chk("halt_flush_cnt", 32'(flush_a), 32'd0);

    // reset out of HALT
    reset = 1'b0;
    #1;
    chk("rst_halt_ctrl", 32'(ctrl_a), 32'(7'b0));
    chk("rst_halt_err", 32'(err_a), 32'd0);
    chk("rst_halt_stall", 32'(stall_a), 32'd0);
    step();
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("post_rst_ctrl", 32'(ctrl_a), 32'(C_NORM));
    step();

    // saturation on the 4-bit instance, then clear beating a stall
    clear_cnt();
    drive(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("sat15_b", 32'(stall_b), 32'd15);
    for (int i = 0; i < 5; i++) step();
    chk("sat20_b", 32'(stall_b), 32'd15);
    chk("sat20_a", 32'(stall_a), 32'd20);
    chk("sat_ctrl_b", 32'(ctrl_b), 32'(C_LDUSE));
    Cnt_Clr = 1'b1;
    step();
    Cnt_Clr = 1'b0;
    chk("clr_b", 32'(stall_b), 32'd0);
    chk("clr_a", 32'(stall_a), 32'd0);
    step();
    chk("after_clr_b", 32'(stall_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
